sd_block_writer: RTL and testbench

Write-path counterpart to the SD card block reader. It takes one 512-byte block from a user-provided buffer and writes it to an already-initialised card in transfer state using WRITE_BLOCK (CMD24). It drives the shared SD command-bus and data-bus engines. It checks the card's CRC-status token, waits out card programming busy, and retries on failure.

---
 rtl/sd_block_writer_if.sv | 42 ++++
 rtl/sd_block_writer.sv | 211 +++++++++++++++++++++
 tb/tb_sd_block_writer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_block_writer_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | sd_block_writer_if : user, buffer, command-bus and data-bus signals    |
// |                      of the SD single-block writer                     |
// | Revision 1.0                                                           |
// +------------------------------------------------------------------------+
interface sd_block_writer_if;
  logic        High_Capacity;
  logic [31:0] Block;
  logic        Write;
  logic        Busy;
  logic [8:0]  Address;
  logic [7:0]  Buffer_Data;
  logic [5:0]  Command;
  logic [31:0] Argument;
  logic [1:0]  Response_Type;
  logic        Execute;
  logic        Cmd_Busy;
  logic        Cmd_Error;
  logic        Data_Start;
  logic [7:0]  Send_Data;
  logic        Data_Clk;
  logic        Data_Busy;
  logic [3:0]  Data_Error;
  logic        SD_Busy;
  logic        Card_Error;

  modport master (
    input  High_Capacity, Block, Write, Buffer_Data, Cmd_Busy, Cmd_Error,
           Data_Clk, Data_Busy, Data_Error, SD_Busy,
    output Busy, Address, Command, Argument, Response_Type, Execute,
           Data_Start, Send_Data, Card_Error
  );

  modport slave (
    output High_Capacity, Block, Write, Buffer_Data, Cmd_Busy, Cmd_Error,
           Data_Clk, Data_Busy, Data_Error, SD_Busy,
    input  Busy, Address, Command, Argument, Response_Type, Execute,
           Data_Start, Send_Data, Card_Error
  );
endinterface
`default_nettype wire

// File: rtl/sd_block_writer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | sd_block_writer : writes one 512-byte buffer to an SD card via CMD24,  |
// |                   checks the CRC-status token, waits out programming   |
// | Revision 1.0                                                           |
// +------------------------------------------------------------------------+
module sd_block_writer #(
  parameter logic [7:0]  MAX_RETRIES  = 8'd3,
  parameter logic [23:0] BUSY_TIMEOUT = 24'hFFFFFF
) (
  input  logic              Clk,
  input  logic              Reset,
  sd_block_writer_if.master bus
);

  localparam logic [5:0] c_CMD24   = 6'd24;
  localparam logic [1:0] c_RESP_R1 = 2'd1;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    SEND_CMD   = 4'd1,
    WAIT_CMD   = 4'd2,
    PREFETCH   = 4'd3,
    STREAM     = 4'd4,
    WAIT_TOKEN = 4'd5,
    WAIT_PROG  = 4'd6,
    RETRY      = 4'd7,
    DONE       = 4'd8,
    STALL      = 4'd9
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] arg_q, arg_d;
  logic [5:0]  cmd_q, cmd_d;
  logic        exec_q, exec_d;
  logic        busy_q, busy_d;
  logic [8:0]  addr_q, addr_d;
  logic [7:0]  send_q, send_d;
  logic        start_q, start_d;
  logic        dclk_q, dclk_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [7:0]  retry_q, retry_d;
  logic [23:0] timer_q, timer_d;
  logic        cerr_q, cerr_d;

  logic [23:0] w_timer_inc;
  logic        w_timeout;

  assign w_timer_inc = timer_q + 24'd1;
  assign w_timeout   = (w_timer_inc == BUSY_TIMEOUT);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      arg_q   <= '0;
      cmd_q   <= '0;
      exec_q  <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      send_q  <= '0;
      start_q <= 1'b0;
      dclk_q  <= 1'b0;
      cnt_q   <= '0;
      retry_q <= '0;
      timer_q <= '0;
      cerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      arg_q   <= arg_d;
      cmd_q   <= cmd_d;
      exec_q  <= exec_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      send_q  <= send_d;
      start_q <= start_d;
      dclk_q  <= dclk_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      timer_q <= timer_d;
      cerr_q  <= cerr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    arg_d   = arg_q;
    cmd_d   = cmd_q;
    exec_d  = exec_q;
    busy_d  = busy_q;
    addr_d  = addr_q;
    send_d  = send_q;
    start_d = 1'b0;
    dclk_d  = dclk_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    timer_d = timer_q;
    cerr_d  = cerr_q;

    unique case (state_q)
      IDLE: begin
        if (bus.Write && !cerr_q) begin
          arg_d   = bus.High_Capacity ? bus.Block : {bus.Block[22:0], 9'd0};
          busy_d  = 1'b1;
          retry_d = '0;
          cmd_d   = c_CMD24;
          exec_d  = 1'b1;
          addr_d  = '0;
          state_d = SEND_CMD;
        end
      end
      // Address is parked at 0 from here on so byte 0 is already
      // waiting on Buffer_Data by the time Prefetch samples it.
      SEND_CMD: begin
        if (bus.Cmd_Busy) begin
          exec_d  = 1'b0;
          state_d = WAIT_CMD;
        end
      end
      WAIT_CMD: begin
        if (!bus.Cmd_Busy) begin
          if (bus.Cmd_Error) begin
            timer_d = '0;
            state_d = RETRY;
          end else begin
            addr_d  = '0;
            state_d = PREFETCH;
          end
        end
      end
      PREFETCH: begin
        send_d  = bus.Buffer_Data;
        addr_d  = 9'd1;
        start_d = 1'b1;
        dclk_d  = bus.Data_Clk;
        cnt_d   = '0;
        state_d = STREAM;
      end
      STREAM: begin
        if (bus.Data_Clk != dclk_q) begin
          dclk_d = bus.Data_Clk;
          send_d = bus.Buffer_Data;
          addr_d = addr_q + 9'd1;
          cnt_d  = cnt_q + 10'd1;
          if (cnt_q == 10'd511) begin
            state_d = WAIT_TOKEN;
          end
        end
      end
      WAIT_TOKEN: begin
        if (!bus.Data_Busy) begin
          timer_d = '0;
          state_d = (bus.Data_Error != 4'd0) ? RETRY : WAIT_PROG;
        end
      end
      WAIT_PROG: begin
        if (!bus.SD_Busy) begin
          state_d = DONE;
        end else begin
          timer_d = w_timer_inc;
          if (w_timeout) begin
            cerr_d  = 1'b1;
            state_d = STALL;
          end
        end
      end
      // A failed attempt may leave the card programming, so the reissue
      // waits for DAT0 to release under the same timeout as Wait_Prog.
      RETRY: begin
        if (retry_q == MAX_RETRIES) begin
          cerr_d  = 1'b1;
          state_d = STALL;
        end else if (!bus.SD_Busy) begin
          retry_d = retry_q + 8'd1;
          exec_d  = 1'b1;
          addr_d  = '0;
          state_d = SEND_CMD;
        end else begin
          timer_d = w_timer_inc;
          if (w_timeout) begin
            cerr_d  = 1'b1;
            state_d = STALL;
          end
        end
      end
      DONE: begin
        if (!bus.Write) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      STALL: begin
        state_d = STALL;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.Busy          = busy_q;
  assign bus.Address       = addr_q;
  assign bus.Command       = cmd_q;
  assign bus.Argument      = arg_q;
  assign bus.Response_Type = c_RESP_R1;
  assign bus.Execute       = exec_q;
  assign bus.Data_Start    = start_q;
  assign bus.Send_Data     = send_q;
  assign bus.Card_Error    = cerr_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_block_writer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_sd_block_writer : self-checking bench with command-bus, data-bus    |
// |                      and buffer models around sd_block_writer          |
// | Revision 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_sd_block_writer;

  typedef struct {
    logic        hc;
    logic [31:0] block;
    logic [3:0]  derr0;
    logic [31:0] exp_arg;
    int          exp_cmds;
  } vec_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;

  sd_block_writer_if sd_if();

  sd_block_writer #(
    .MAX_RETRIES  (8'd3),
    .BUSY_TIMEOUT (24'd1000)
  ) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (sd_if)
  );

  logic [7:0]  mem [512];
  logic [7:0]  sb [$];
  logic [31:0] exp_args [$];
  logic [3:0]  derr_q [$];
  vec_t        vecs [4];

  int n_tests, n_fail;
  int n_cmds, n_starts, n_done;
  int byte_idx, token_cyc, prog_cycles;
  bit abort, cmd_err_all, model_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous buffer: data for an address appears one clock later.
  always @(posedge clk) sd_if.Buffer_Data <= mem[sd_if.Address];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
  endtask

  // Command-bus model
  initial begin
    sd_if.Cmd_Busy  = 1'b0;
    sd_if.Cmd_Error = 1'b0;
    forever begin
      @(negedge clk);
      if (sd_if.Execute && !sd_if.Cmd_Busy) begin
        n_cmds++;
        check("cmd_index", 32'(sd_if.Command), 32'd24);
        if (exp_args.size() == 0) fail_now("cmd_unexpected");
        else check("cmd_arg", sd_if.Argument, exp_args.pop_front());
        repeat (2) @(negedge clk);
        sd_if.Cmd_Busy  = 1'b1;
        sd_if.Cmd_Error = 1'b0;
        @(negedge clk);
        check("exec_drop_after_handoff", 32'(sd_if.Execute), 32'd0);
        repeat (3) @(negedge clk);
        sd_if.Cmd_Error = cmd_err_all;
        sd_if.Cmd_Busy  = 1'b0;
      end
    end
  end

  // Data-bus model: consumes 512 bytes per Data_Start, then token + programming busy
  initial begin
    bit aborted;
    sd_if.Data_Busy  = 1'b0;
    sd_if.Data_Error = 4'd0;
    sd_if.Data_Clk   = 1'b0;
    sd_if.SD_Busy    = 1'b0;
    forever begin
      @(negedge clk);
      if (sd_if.Data_Start) begin
        n_starts++;
        model_busy = 1'b1;
        aborted = 1'b0;
        byte_idx = 0;
        sd_if.Data_Busy = 1'b1;
        @(negedge clk);
        check("start_pulse_width", 32'(sd_if.Data_Start), 32'd0);
        for (int k = 0; k < 512; k++) begin
          if (abort) begin
            aborted = 1'b1;
            break;
          end
          if (sb.size() == 0) fail_now("byte_extra");
          else check("stream_byte", 32'(sd_if.Send_Data), 32'(sb.pop_front()));
          sd_if.Data_Clk = ~sd_if.Data_Clk;
          byte_idx = k + 1;
          repeat (2) @(negedge clk);
        end
        if (!aborted) begin
          repeat (3) @(negedge clk);
          sd_if.Data_Error = (derr_q.size() != 0) ? derr_q.pop_front() : 4'd0;
          sd_if.Data_Busy  = 1'b0;
          sd_if.SD_Busy    = 1'b1;
          token_cyc = cyc;
          n_done++;
          @(negedge clk);
          sd_if.Data_Error = 4'd0;
          for (int p = 0; p < prog_cycles && !abort; p++) @(negedge clk);
        end
        sd_if.Data_Busy  = 1'b0;
        sd_if.Data_Error = 4'd0;
        sd_if.SD_Busy    = 1'b0;
        model_busy = 1'b0;
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_busy",     32'(sd_if.Busy),          32'd0);
    check("rst_address",  32'(sd_if.Address),       32'd0);
    check("rst_command",  32'(sd_if.Command),       32'd0);
    check("rst_argument", sd_if.Argument,           32'd0);
    check("rst_resp",     32'(sd_if.Response_Type), 32'd1);
    check("rst_execute",  32'(sd_if.Execute),       32'd0);
    check("rst_start",    32'(sd_if.Data_Start),    32'd0);
    check("rst_senddata", 32'(sd_if.Send_Data),     32'd0);
    check("rst_carderr",  32'(sd_if.Card_Error),    32'd0);
  endtask

  task automatic push_expect(input vec_t v);
    for (int c = 0; c < v.exp_cmds; c++) begin
      exp_args.push_back(v.exp_arg);
      for (int i = 0; i < 512; i++) sb.push_back(8'(i));
    end
    if (v.derr0 != 4'd0) begin
      derr_q.push_back(v.derr0);
      derr_q.push_back(4'd0);
    end
  endtask

  task automatic run_xfer(input vec_t v);
    int cmd_base, start_base, done_base, t;
    cmd_base = n_cmds; start_base = n_starts; done_base = n_done;
    push_expect(v);
    @(negedge clk);
    sd_if.High_Capacity = v.hc;
    sd_if.Block         = v.block;
    sd_if.Write         = 1'b1;
    t = 0;
    while (!((n_done - done_base) >= v.exp_cmds && !model_busy && !sd_if.SD_Busy) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) fail_now("xfer_timeout");
    repeat (5) @(negedge clk);
    check("xfer_cmd_count",   32'(n_cmds - cmd_base),     32'(v.exp_cmds));
    check("xfer_start_count", 32'(n_starts - start_base), 32'(v.exp_cmds));
    check("xfer_argument",    sd_if.Argument,             v.exp_arg);
    check("xfer_busy_held",   32'(sd_if.Busy),            32'd1);
    check("xfer_card_err",    32'(sd_if.Card_Error),      32'd0);
    check("xfer_bytes_left",  32'(sb.size()),             32'd0);
    sd_if.Write = 1'b0;
    #1;
    check("busy_before_edge", 32'(sd_if.Busy), 32'd1);
    @(negedge clk);
    check("busy_after_release", 32'(sd_if.Busy), 32'd0);
  endtask

  initial begin
    int t, cmd_base;
    n_tests = 0; n_fail = 0;
    n_cmds = 0; n_starts = 0; n_done = 0;
    abort = 1'b0; cmd_err_all = 1'b0; model_busy = 1'b0;
    prog_cycles = 10; byte_idx = 0; token_cyc = 0;
    rst_n = 1'b0;
    sd_if.Write = 1'b0;
    sd_if.High_Capacity = 1'b0;
    sd_if.Block = 32'd0;
    for (int i = 0; i < 512; i++) mem[i] = 8'(i);

    vecs[0] = '{hc: 1'b0, block: 32'd5,          derr0: 4'd0,    exp_arg: 32'h00000A00, exp_cmds: 1};
    vecs[1] = '{hc: 1'b1, block: 32'h00012345,   derr0: 4'd0,    exp_arg: 32'h00012345, exp_cmds: 1};
    vecs[2] = '{hc: 1'b0, block: 32'd3,          derr0: 4'b0101, exp_arg: 32'h00000600, exp_cmds: 2};
    vecs[3] = '{hc: 1'b0, block: 32'hFFFFFFFF,   derr0: 4'd0,    exp_arg: 32'hFFFFFE00, exp_cmds: 1};

    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_xfer(vecs[i]);

    // Reset part-way through the stream, then a clean transfer
    push_expect(vecs[0]);
    @(negedge clk);
    sd_if.High_Capacity = 1'b0;
    sd_if.Block = 32'd5;
    sd_if.Write = 1'b1;
    t = 0;
    while (byte_idx != 200 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) fail_now("reach_byte_200");
    rst_n = 1'b0;
    sd_if.Write = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    t = 0;
    while (model_busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) fail_now("model_abort");
    sb.delete();
    exp_args.delete();
    derr_q.delete();
    abort = 1'b0;
    run_xfer('{hc: 1'b1, block: 32'd7, derr0: 4'd0, exp_arg: 32'd7, exp_cmds: 1});

    // Command error on every attempt: initial try plus three retries
    cmd_err_all = 1'b1;
    for (int c = 0; c < 4; c++) exp_args.push_back(32'h00000E00);
    cmd_base = n_cmds;
    @(negedge clk);
    sd_if.High_Capacity = 1'b0;
    sd_if.Block = 32'd7;
    sd_if.Write = 1'b1;
    t = 0;
    while (!sd_if.Card_Error && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) fail_now("cmd_err_card_error");
    repeat (50) @(negedge clk);
    check("retry_cmd_count", 32'(n_cmds - cmd_base), 32'd4);
    check("retry_card_err",  32'(sd_if.Card_Error),  32'd1);
    check("retry_busy",      32'(sd_if.Busy),        32'd1);
    sd_if.Write = 1'b0;
    repeat (5) @(negedge clk);
    sd_if.Write = 1'b1;
    repeat (50) @(negedge clk);
    check("stall_ignores_write", 32'(n_cmds - cmd_base), 32'd4);
    check("stall_busy",          32'(sd_if.Busy),        32'd1);
    check("retry_args_left",     32'(exp_args.size()),   32'd0);
    cmd_err_all = 1'b0;
    sd_if.Write = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("card_err_cleared", 32'(sd_if.Card_Error), 32'd0);

    // Card never leaves programming busy
    prog_cycles = 5000;
    push_expect('{hc: 1'b1, block: 32'd9, derr0: 4'd0, exp_arg: 32'd9, exp_cmds: 1});
    @(negedge clk);
    sd_if.High_Capacity = 1'b1;
    sd_if.Block = 32'd9;
    sd_if.Write = 1'b1;
    t = 0;
    while (!sd_if.Card_Error && t < 6000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 6000) fail_now("prog_timeout_card_error");
    else check("prog_timeout_window", 32'((cyc - token_cyc) >= 997 && (cyc - token_cyc) <= 1005), 32'd1);
    cmd_base = n_cmds;
    repeat (100) @(negedge clk);
    check("timeout_no_cmd",  32'(n_cmds - cmd_base), 32'd0);
    check("timeout_exec",    32'(sd_if.Execute),     32'd0);
    check("timeout_busy",    32'(sd_if.Busy),        32'd1);
    check("timeout_bytes",   32'(sb.size()),         32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
